// File: rtl/rv_trace_pkg.sv
// rv_trace_pkg: shared types and helpers for the rv_trace_buffer instruction-trace monitor.
// Revision: 1.0
`default_nettype none

package rv_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  // Entry layout at the default 32-bit widths; the RTL packs the same field order generically.
  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_trace_ram.sv
// rv_trace_ram: DEPTH x WIDTH trace storage, one synchronous write port, one combinational read port.
// Revision: 1.0
`default_nettype none

module rv_trace_ram
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/rv_trace_buffer.sv
// rv_trace_buffer: PC-triggered circular trace capture of retired instructions, drained oldest-first.
// Optional opcode filter enabled by macro RV_TRACE_OPCODE_FILTER_EN. Revision: 1.0
`default_nettype none

module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ILEN      = 32,
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 32,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trc_valid,
  input  logic [XLEN-1:0]          trc_pc,
  input  logic [ILEN-1:0]          trc_instr,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
`ifdef RV_TRACE_OPCODE_FILTER_EN
  input  logic                     flt_en,
  input  logic [6:0]               flt_opcode,
`endif
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [ILEN-1:0]          rd_instr,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PW        = ptr_width(DEPTH);
  localparam int              EW        = CYC_W + XLEN + ILEN;
  localparam logic [PW:0]     FULL      = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   POST_INIT = PW'(POST_TRIG);
  localparam logic [PW-1:0]   POST_LAST = PW'(1);

  trace_state_t   st_q, st_d;
  logic [PW-1:0]  wr_ptr, rd_ptr, post_cnt;
  logic [PW:0]    cnt;
  logic [CYC_W-1:0] cyc;
  logic           eligible, capturing, trig_hit, pop;
  logic [EW-1:0]  rd_entry;

`ifdef RV_TRACE_OPCODE_FILTER_EN
  assign eligible = !flt_en || (trc_instr[6:0] == flt_opcode);
`else
  assign eligible = 1'b1;
`endif

  // arm takes priority: an instruction retiring in the arm cycle is dropped.
  assign capturing = trc_valid && eligible && !arm && (st_q == ARMED || st_q == POST);
  assign trig_hit  = trc_valid && trig_en && !arm && (st_q == ARMED) && (trc_pc == trig_pc);
  assign rd_valid  = (st_q == FROZEN) && (cnt != '0);
  assign pop       = rd_valid && rd_ready && !arm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:   st_d = IDLE;
      ARMED:  if (trig_hit) st_d = (POST_TRIG == 0) ? FROZEN : POST;
      POST:   if (capturing && post_cnt == POST_LAST) st_d = FROZEN;
      FROZEN: if (cnt == '0 || (pop && cnt == (PW+1)'(1))) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (arm) st_d = ARMED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (arm || st_q == IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else if (capturing) begin
        wr_ptr <= wr_ptr + 1'b1;
        // Full buffer: the write overwrites the oldest entry, so the read side slides too.
        if (cnt == FULL) begin
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= cnt - 1'b1;
      end

      if (arm) begin
        post_cnt <= '0;
      end else if (trig_hit) begin
        post_cnt <= POST_INIT;
      end else if (st_q == POST && capturing) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

  rv_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (capturing),
    .waddr (wr_ptr),
    .wdata ({cyc, trc_pc, trc_instr}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign {rd_cycle, rd_pc, rd_instr} = rd_valid ? rd_entry : '0;
  assign state = st_q;
  assign count = cnt;

endmodule

`default_nettype wire
